// File: rtl/mux_rr_reg_if.sv
// mux_rr_reg_if: handshake bundle between producers, the mux_rr_reg block
// and its single downstream consumer.
//   mode      : 0 = manual select (sel), 1 = round-robin scan
//   sel       : channel index used in manual mode
//   in_data   : concatenated channel words, channel i at [i*DATA_W +: DATA_W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (at most one bit set)
//   out_data  : registered output word
//   out_ch    : channel that sourced out_data
//   out_valid : output register holds a word
//   out_ready : consumer accepts the word
// The master modport is the environment side (producers + consumer); the
// slave modport is the mux itself.
interface mux_rr_reg_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered NUM_CH:1 multiplexer with per-channel valid/ready,
// a one-entry output register with back-pressure, and manual or
// round-robin channel selection.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_reg_if slave modport (channel inputs, output register)
module mux_rr_reg #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_reg_if.slave  bus
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_last_q,   rr_last_d;

    logic              can_load;
    logic              cand_vld;
    logic [SEL_W-1:0]  cand;
    logic [NUM_CH-1:0] cand_oh;
    logic [DATA_W-1:0] cand_data;
    logic              xfer;

    logic              hi_found, lo_found;
    logic [SEL_W-1:0]  hi_idx,   lo_idx;

    assign can_load = !out_valid_q || bus.out_ready;

    // Round-robin search split into two windows: channels above rr_last
    // first, then 0..rr_last. Walking downward leaves the lowest index of
    // each window, which gives the rr_last+1, rr_last+2, ... order with an
    // explicit wrap at NUM_CH (no reliance on SEL_W overflow).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (i > int'(rr_last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        if (!bus.mode) begin
            // sel values at or beyond NUM_CH name no channel
            cand_vld = (int'(bus.sel) < NUM_CH);
            cand     = bus.sel;
        end else begin
            cand_vld = hi_found || lo_found;
            cand     = hi_found ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        cand_oh   = '0;
        cand_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_oh[i] = cand_vld && (cand == SEL_W'(i));
            if (cand_oh[i]) begin
                cand_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = can_load && |(cand_oh & bus.in_valid);

    // Manual mode may offer ready on a channel that is not valid; the
    // transfer still requires that channel's valid. Ready is forced low
    // while reset is held.
    assign bus.in_ready = {NUM_CH{can_load && rst_n}} & cand_oh;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_last_d   = rr_last_q;
        if (xfer) begin
            // covers both an empty register and drain-plus-refill
            out_valid_d = 1'b1;
            out_data_d  = cand_data;
            out_ch_d    = cand;
            if (bus.mode) begin
                rr_last_d = cand;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Successor to the team's combinational 4:1 selector. Adds per-channel valid/ready handshakes, a one-entry output register with back-pressure, and two selection modes: manual select, and round-robin scan over valid channels.
- Sits between several producer streams and a single downstream consumer.

Parameters:
- NUM_CH, default 4: number of input channels; must be at least 2.
- DATA_W, default 8: width of each channel's data word.
- SEL_W, default $clog2(NUM_CH): width of the sel and out_ch fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = manual (use sel), 1 = round-robin scan.
- sel  input  SEL_W  channel index used in manual mode.
- in_data  input  NUM_CH*DATA_W  concatenated channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit is set at a time.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  index of the channel that sourced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_last=NUM_CH-1, so ch0 has first priority after reset.
  - in_ready is combinational and reads all-zero while in reset.
- can_load = !out_valid || out_ready.
- Candidate channel, computed combinationally each cycle:
  - Manual mode: cand=sel. If sel>=NUM_CH, there is no candidate.
  - Scan mode: cand is the first i with in_valid[i]=1, searching rr_last+1, rr_last+2, … with modulo-NUM_CH wrap. If no in_valid bit is set, there is no candidate.
- in_ready:
  - in_ready[cand]=can_load when a candidate exists.
  - All other bits are 0.
  - In manual mode, in_ready[sel] may be 1 even when in_valid[sel]=0.
- Transfer occurs when in_valid[cand] && in_ready[cand]. On the next rising edge:
  - out_data=channel cand's data, out_ch=cand, out_valid=1.
  - In scan mode only, rr_last=cand.
- Latency: 1 cycle from transfer to out_valid.
- Full throughput: one word per cycle while out_ready=1.
- Drain without refill: out_valid && out_ready with no transfer → out_valid=0 next edge. out_data and out_ch hold their last values.
- Stall: out_valid && !out_ready → out_data, out_ch and out_valid are held unchanged; every in_ready bit is 0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, out_valid stays 1, and no bubble is inserted.
- Mode and sel changes:
  - Take effect for the candidate in the same cycle, since selection is combinational.
  - A word already in the output register is unaffected.
  - rr_last keeps its value across manual-mode periods.
- Non-power-of-2 NUM_CH: round-robin wrap is explicit modulo NUM_CH, never a natural SEL_W overflow.
- No data is lost or duplicated: each accepted input word appears on out_data exactly once.
- Reset asserted mid-operation: the word in the output register is discarded immediately and out_valid falls asynchronously.

Test Plan:
- Reset, then manual mode, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- Scan mode, in_valid=4'b1111 held, channel i data=8'h10+i, out_ready=1 → out_ch sequence 0,1,2,3,0,…, one word per cycle, data matches the channel.
- Scan mode, in_valid=4'b1001, out_ready=1 → out_ch alternates 0,3,0,3; ch1 and ch2 are never granted.
- Scan mode, out_ready=0 for 3 cycles after the first load → out_data and out_ch stable, in_ready=0; on release, the next grant follows rr_last with nothing skipped or duplicated.
- Manual mode, sel=3'd5 with NUM_CH=5 (SEL_W=3) → in_ready=0, no load. Scan mode with NUM_CH=5 → pointer wraps 4→0.
- Assert rst_n=0 mid-stream with out_valid=1 → out_valid drops immediately. After release, the first scan grant goes to the lowest valid channel.
